sd_cmd_engine: RTL and testbench
================================

Name: sd_cmd_engine

Overview:
Parametrised SD-bus command-line engine. Serialises one 48-bit host command (CRC7 computed on the fly) onto CMD, then optionally receives and checks a 48-bit or 136-bit card response. It runs a response timeout and a post-command gap, and generates SD_CLK from CLK through a programmable divider. It sits between the card-init/transfer sequencer (which issues START with index/arg/type) and the top-level CMD pad tristate.

Parameters:
CLK_DIV, 2, CLK cycles per SD_CLK half-period (>=1); SD_CLK = CLK/(2*CLK_DIV)
RESP_TIMEOUT, 64, SD_CLK rising edges allowed between last command bit and response start bit (NCR)
GAP_CLKS, 8, SD_CLK cycles with CMD released after command/response (NCC/NRC)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
START  in  1  one-cycle request; accepted only when BUSY=0
CMD_INDEX  in  6  command index, latched on accepted START
CMD_ARG  in  32  command argument, latched on accepted START
RESP_TYPE  in  2  00 none, 01 48-bit with CRC (R1/R6/R7), 10 136-bit (R2), 11 48-bit no CRC (R3)
BUSY  out  1  high from accepted START until DONE
DONE  out  1  one-CLK pulse at completion
RESP  out  128  response payload (see Behaviour)
TIMEOUT  out  1  no start bit within RESP_TIMEOUT; valid with DONE, held until next START
CRC_ERR  out  1  response CRC7 mismatch; valid with DONE, held until next START
FRAME_ERR  out  1  transmission bit != 0 or end bit != 1; valid with DONE, held until next START
SD_CLK  out  1  card clock
CMD_OUT  out  1  CMD drive value
CMD_OE  out  1  CMD output enable (top level builds the tristate)
CMD_IN  in  1  CMD pad input (pulled up externally)

Behaviour:
- Reset (any state, mid-command included): state IDLE, SD_CLK=0, CMD_OE=0, CMD_OUT=1, BUSY=0, DONE=0, RESP=0, all flags 0, divider and bit counters 0.
- Divider: counter 0..CLK_DIV-1; a "tick" at terminal count toggles SD_CLK. Rising tick = SD_CLK 0->1; falling tick = 1->0. SD_CLK is held at 0 in IDLE and runs in all other states.
- CMD_OUT changes only on falling ticks. CMD_IN is sampled only on rising ticks.
- States:
  - IDLE: START accepted -> latch inputs, clear flags and RESP, BUSY=1, go SEND. START while BUSY is ignored.
  - SEND: frame = 0,1,CMD_INDEX,CMD_ARG,CRC7,1, MSB first. CMD_OE=1 from the first falling tick. CRC7 uses polynomial x^7+x^3+1, init 0, over frame bits 47..8; bits 7..1 are the CRC register. After bit 0 is held for its full SD_CLK period: RESP_TYPE=00 -> GAP, else WAIT_RESP. CMD_OE=0 from the falling tick after bit 0.
  - WAIT_RESP: count rising ticks. CMD_IN=0 sampled -> RECV (start bit counted). Count reaches RESP_TIMEOUT with no 0 -> TIMEOUT=1, go GAP.
  - RECV: shift in remaining 47 or 135 bits.
    - 48-bit: RESP[37:0]=frame[45:8], RESP[127:38]=0; CRC over frame[47:8].
    - 136-bit: RESP[119:0]=frame[127:8], RESP[127:120]=0; CRC over frame[127:8].
    - CRC_ERR=1 if computed CRC != frame[7:1] (never set for RESP_TYPE=11).
    - FRAME_ERR=1 if tx bit (frame[46] or [134]) = 1 or end bit = 0.
    - After the end bit -> GAP.
  - GAP: CMD_OE=0, SD_CLK runs GAP_CLKS cycles, then DONE=1 for one CLK, BUSY=0 in the same cycle, SD_CLK parked 0, go IDLE.
- Latency, RESP_TYPE=00: DONE arrives (48+GAP_CLKS)*2*CLK_DIV CLK cycles (+/-2) after START.
- A response start bit arriving on the same rising tick the timeout count expires is accepted; the timeout is not flagged.

Decomposition:
- Shared package sd_pkg: RESP_TYPE encodings, state enum, frame length constants (48, 136), CRC7 polynomial 7'h09, default CLK_DIV/RESP_TIMEOUT/GAP_CLKS.
- Sub-module sd_crc7: serial CRC7 with clear, enable, data bit, 7-bit crc out. Two instances: transmit and receive.

Test Plan:
- Reset, then START CMD0 (index 0, arg 0, type 00): CMD bitstream is 0x40_0000_0000_95 MSB first, CRC7=0x4A; DONE after 56 SD clocks; no flags set.
- START CMD8 (index 8, arg 0x000001AA, type 01), bench card replies with a valid R7 echo after 5 clocks: CMD bits end with CRC7=0x43 (0x87 byte); RESP[37:0]=0x08_000001AA; CRC_ERR=0, FRAME_ERR=0, TIMEOUT=0.
- Same as above but the card never drives CMD: TIMEOUT=1 after exactly 64 rising edges past the command end bit; DONE then follows 8 SD clocks later.
- R2 (type 10) with a 136-bit frame whose frame[127:8]=0x0123…EF (bench-computed CRC): RESP[119:0] matches and CRC_ERR=0; rerun with one payload bit flipped -> CRC_ERR=1.
- R3 (type 11) with CRC field 7'h7F and end bit 0: CRC_ERR=0, FRAME_ERR=1.
- Assert RST mid-SEND at bit 20, then START CMD55 arg 0: all outputs at reset values the next cycle; the new frame is 0x77_0000_0000_65 with a clean DONE. A START pulsed while BUSY causes no restart.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line engine: response
// encodings, FSM states, frame lengths and the serial CRC7 step.
package sd_pkg;

   typedef enum logic [1:0] {
      RESP_NONE = 2'b00,
      RESP_R1   = 2'b01,
      RESP_R2   = 2'b10,
      RESP_R3   = 2'b11
   } resp_type_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_RESP = 3'd2,
      ST_RECV      = 3'd3,
      ST_GAP       = 3'd4
   } sd_state_e;

   localparam int FRAME_SHORT = 48;
   localparam int FRAME_LONG  = 136;

   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam int DEF_CLK_DIV      = 2;
   localparam int DEF_RESP_TIMEOUT = 64;
   localparam int DEF_GAP_CLKS     = 8;

   // One bit of x^7+x^3+1, MSB-first message order.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data);
      logic fb;
      fb = data ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clear has priority over enable.
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       en,
   input  logic       data,
   output logic [6:0] crc
);

   always_ff @(posedge clk) begin
      if (clr) begin
         crc <= 7'h00;
      end else if (en) begin
         crc <= crc7_step(crc, data);
      end
   end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends one 48-bit command, optionally receives a 48/136-bit
// response, then holds CMD released for the gap before signalling DONE.
module sd_cmd_engine
   import sd_pkg::*;
#(
   parameter int CLK_DIV      = DEF_CLK_DIV,
   parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT,
   parameter int GAP_CLKS     = DEF_GAP_CLKS
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [5:0]   CMD_INDEX,
   input  logic [31:0]  CMD_ARG,
   input  logic [1:0]   RESP_TYPE,
   output logic         BUSY,
   output logic         DONE,
   output logic [127:0] RESP,
   output logic         TIMEOUT,
   output logic         CRC_ERR,
   output logic         FRAME_ERR,
   output logic         SD_CLK,
   output logic         CMD_OUT,
   output logic         CMD_OE,
   input  logic         CMD_IN,
   output sd_state_e    dbg_state
);

   // Handshake: START is a one-cycle request taken only while BUSY is low; BUSY
   // stays high until the cycle DONE pulses, and RESP/flags hold until next START.
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] TO_LIM   = 16'(RESP_TIMEOUT);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CLKS - 1);

   sd_state_e     state, state_n;
   logic [15:0]   div_cnt, wait_cnt, gap_cnt;
   logic [7:0]    bit_cnt, rx_last, rx_pos, crc_top;
   logic [39:0]   tx_sh;
   logic [126:0]  rx_sh;
   logic [127:0]  rx_frame;
   logic [1:0]    rtype;
   logic [6:0]    tx_crc, rx_crc;
   logic [2:0]    crc_idx;
   logic          tick, rise, fall, accept, long_resp, tx_bit, tx_bit_err;
   logic          tx_crc_en, rx_crc_en, to_hit, rx_end, gap_end, send_end;

   assign dbg_state = state;
   assign accept    = (state == ST_IDLE) && START;
   assign tick      = (state != ST_IDLE) && (div_cnt == DIV_LAST);
   assign rise      = tick && !SD_CLK;
   assign fall      = tick && SD_CLK;
   assign long_resp = (rtype == RESP_R2);
   assign rx_last   = long_resp ? 8'(FRAME_LONG - 1) : 8'(FRAME_SHORT - 1);
   assign crc_top   = long_resp ? 8'd127 : 8'd47;
   assign rx_pos    = rx_last - bit_cnt;
   assign rx_frame  = {rx_sh, CMD_IN};
   assign crc_idx   = 3'(8'd46 - bit_cnt);

   assign tx_crc_en = (state == ST_SEND) && fall && (bit_cnt < 8'd40);
   // The short-frame CRC covers the start bit, which is seen while still waiting.
   assign rx_crc_en = rise && (((state == ST_WAIT_RESP) && !CMD_IN && !long_resp) ||
                               ((state == ST_RECV) && (rx_pos >= 8'd8) && (rx_pos <= crc_top)));

   sd_crc7 u_tx_crc (.clk(CLK), .clr(RST | accept), .en(tx_crc_en), .data(tx_sh[39]), .crc(tx_crc));
   sd_crc7 u_rx_crc (.clk(CLK), .clr(RST | accept), .en(rx_crc_en), .data(CMD_IN),    .crc(rx_crc));

   always_comb begin
      tx_bit = 1'b1;
      if (bit_cnt < 8'd40) begin
         tx_bit = tx_sh[39];
      end else if (bit_cnt < 8'd47) begin
         tx_bit = tx_crc[crc_idx];
      end
   end

   always_comb begin
      state_n  = state;
      to_hit   = 1'b0;
      rx_end   = 1'b0;
      gap_end  = 1'b0;
      send_end = 1'b0;
      case (state)
         ST_IDLE: if (START) state_n = ST_SEND;
         ST_SEND: begin
            if (fall && (bit_cnt == 8'(FRAME_SHORT))) begin
               send_end = 1'b1;
               state_n  = (rtype == RESP_NONE) ? ST_GAP : ST_WAIT_RESP;
            end
         end
         ST_WAIT_RESP: begin
            // A start bit on the expiring edge wins over the timeout.
            if (rise) begin
               if (!CMD_IN) begin
                  state_n = ST_RECV;
               end else if (wait_cnt + 16'd1 == TO_LIM) begin
                  to_hit  = 1'b1;
                  state_n = ST_GAP;
               end
            end
         end
         ST_RECV: begin
            if (rise && (bit_cnt == rx_last)) begin
               rx_end  = 1'b1;
               state_n = ST_GAP;
            end
         end
         ST_GAP: begin
            if (fall && (gap_cnt >= GAP_LAST)) begin
               gap_end = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         div_cnt    <= '0;
         SD_CLK     <= 1'b0;
         CMD_OE     <= 1'b0;
         CMD_OUT    <= 1'b1;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         RESP       <= '0;
         TIMEOUT    <= 1'b0;
         CRC_ERR    <= 1'b0;
         FRAME_ERR  <= 1'b0;
         bit_cnt    <= '0;
         wait_cnt   <= '0;
         gap_cnt    <= '0;
         tx_sh      <= '0;
         rx_sh      <= '0;
         rtype      <= RESP_NONE;
         tx_bit_err <= 1'b0;
      end else begin
         state <= state_n;
         DONE  <= 1'b0;
         if ((state == ST_IDLE) || (state_n == ST_IDLE)) begin
            div_cnt <= '0;
            SD_CLK  <= 1'b0;
         end else if (tick) begin
            div_cnt <= '0;
            SD_CLK  <= ~SD_CLK;
         end else begin
            div_cnt <= div_cnt + 16'd1;
         end

         if (accept) begin
            rtype      <= RESP_TYPE;
            tx_sh      <= {2'b01, CMD_INDEX, CMD_ARG};
            BUSY       <= 1'b1;
            RESP       <= '0;
            TIMEOUT    <= 1'b0;
            CRC_ERR    <= 1'b0;
            FRAME_ERR  <= 1'b0;
            tx_bit_err <= 1'b0;
            bit_cnt    <= '0;
         end

         if ((state == ST_SEND) && fall) begin
            if (send_end) begin
               CMD_OE   <= 1'b0;
               CMD_OUT  <= 1'b1;
               bit_cnt  <= '0;
               wait_cnt <= '0;
               gap_cnt  <= 16'd1;   // the releasing edge is the first gap edge
            end else begin
               CMD_OE  <= 1'b1;
               CMD_OUT <= tx_bit;
               bit_cnt <= bit_cnt + 8'd1;
               if (bit_cnt < 8'd40) tx_sh <= {tx_sh[38:0], 1'b0};
            end
         end

         if ((state == ST_WAIT_RESP) && rise) begin
            wait_cnt <= wait_cnt + 16'd1;
            if (!CMD_IN) begin
               bit_cnt <= 8'd1;
               rx_sh   <= '0;
            end else if (to_hit) begin
               TIMEOUT <= 1'b1;
               gap_cnt <= '0;
            end
         end

         if ((state == ST_RECV) && rise) begin
            rx_sh   <= {rx_sh[125:0], CMD_IN};
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == 8'd1) tx_bit_err <= CMD_IN;
            if (rx_end) begin
               RESP      <= long_resp ? {8'h00, rx_frame[127:8]} : {90'h0, rx_frame[45:8]};
               CRC_ERR   <= (rtype != RESP_R3) && (rx_crc != rx_frame[7:1]);
               FRAME_ERR <= tx_bit_err | ~rx_frame[0];
               gap_cnt   <= '0;
            end
         end

         if ((state == ST_GAP) && fall) begin
            gap_cnt <= gap_cnt + 16'd1;
            if (gap_end) begin
               DONE <= 1'b1;
               BUSY <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: directed steps plus randomized R1
// exchanges, with a card model and a CRC7 reference built by polynomial division.
module tb_sd_cmd_engine;
   import sd_pkg::*;

   localparam int CD = 2;
   localparam int TO = 64;
   localparam int GC = 8;

   logic         CLK = 1'b0, RST = 1'b1, START = 1'b0, CMD_IN = 1'b1;
   logic [5:0]   CMD_INDEX = '0;
   logic [31:0]  CMD_ARG = '0;
   logic [1:0]   RESP_TYPE = '0;
   logic         BUSY, DONE, TIMEOUT, CRC_ERR, FRAME_ERR, SD_CLK, CMD_OUT, CMD_OE;
   logic [127:0] RESP;
   sd_state_e    dbg_state;

   sd_cmd_engine #(.CLK_DIV(CD), .RESP_TIMEOUT(TO), .GAP_CLKS(GC)) dut (
      .CLK(CLK), .RST(RST), .START(START), .CMD_INDEX(CMD_INDEX), .CMD_ARG(CMD_ARG),
      .RESP_TYPE(RESP_TYPE), .BUSY(BUSY), .DONE(DONE), .RESP(RESP), .TIMEOUT(TIMEOUT),
      .CRC_ERR(CRC_ERR), .FRAME_ERR(FRAME_ERR), .SD_CLK(SD_CLK), .CMD_OUT(CMD_OUT),
      .CMD_OE(CMD_OE), .CMD_IN(CMD_IN), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   int   total = 0, bad = 0;
   int   cyc = 0, rises = 0, falls = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
   int   to_cyc = 0, to_rise = 0, oe_off_rise = 0;
   bit   released = 1'b0, busy_at_done = 1'b0;
   logic sd_q = 1'b0, oe_q = 1'b0, to_q = 1'b0;
   logic tx_q[$];

   // bus monitor, evaluated just after each active edge
   always @(posedge CLK) begin
      #1;
      cyc++;
      if (SD_CLK && !sd_q) begin
         rises++;
         if (CMD_OE) tx_q.push_back(CMD_OUT);
      end
      if (!SD_CLK && sd_q) falls++;
      if (oe_q && !CMD_OE) begin
         released    = 1'b1;
         oe_off_rise = rises;
      end
      if (TIMEOUT && !to_q) begin
         to_cyc  = cyc;
         to_rise = rises;
      end
      if (DONE) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = BUSY;
      end
      sd_q = SD_CLK;
      oe_q = CMD_OE;
      to_q = TIMEOUT;
   end

   // reference model
   function automatic logic [6:0] crc7_ref(input logic [127:0] msg, input int n);
      logic [134:0] r;
      r = {msg, 7'b0};
      for (int i = n + 6; i >= 7; i--) begin
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      end
      return r[6:0];
   endfunction

   function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] h;
      h = {2'b01, idx, arg};
      return {h, crc7_ref({88'b0, h}, 40), 1'b1};
   endfunction

   function automatic logic [47:0] r1_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] h;
      h = {2'b00, idx, arg};
      return {h, crc7_ref({88'b0, h}, 40), 1'b1};
   endfunction

   // scoreboard helpers
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
      total++;
      assert (v >= lo && v <= hi) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_sdclk"}, SD_CLK, 1'b0);
      chk({tag, "_oe"}, CMD_OE, 1'b0);
      chk({tag, "_out"}, CMD_OUT, 1'b1);
      chk({tag, "_busy"}, BUSY, 1'b0);
      chk({tag, "_done"}, DONE, 1'b0);
      chk({tag, "_resp"}, RESP, 128'h0);
      chk({tag, "_flags"}, {TIMEOUT, CRC_ERR, FRAME_ERR}, 3'b000);
      chk({tag, "_state"}, dbg_state, ST_IDLE);
   endtask

   task automatic check_tx(input string tag, input logic [47:0] exp);
      logic [47:0] f;
      f = '0;
      foreach (tx_q[i]) f = {f[46:0], tx_q[i]};
      chk({tag, "_txlen"}, tx_q.size(), 48);
      chk({tag, "_txframe"}, f, exp);
   endtask

   // driver tasks
   task automatic send_start(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
      @(negedge CLK);
      tx_q.delete();
      released  = 1'b0;
      done_cnt  = 0;
      CMD_INDEX = idx;
      CMD_ARG   = arg;
      RESP_TYPE = rt;
      START     = 1'b1;
      start_cyc = cyc;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_fall();
      int f0, n;
      f0 = falls;
      n  = 0;
      while (falls == f0 && n < 1000) begin
         @(negedge CLK);
         n++;
      end
   endtask

   task automatic card_respond(input logic [135:0] fr, input int len, input int dly);
      int n;
      n = 0;
      if (len == 0) return;
      while (!released && n < 5000) begin
         @(negedge CLK);
         n++;
      end
      repeat (dly) wait_fall();
      for (int i = len - 1; i >= 0; i--) begin
         CMD_IN = fr[i];
         wait_fall();
      end
      CMD_IN = 1'b1;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(negedge CLK);
         n++;
      end
      chk("done_seen", done_cnt != 0, 1'b1);
      repeat (3) @(negedge CLK);
      chk("done_single_pulse", done_cnt, 1);
      chk("busy_low_with_done", busy_at_done, 1'b0);
   endtask

   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input logic [135:0] fr, input int len, input int dly);
      send_start(idx, arg, rt);
      chk("busy_after_start", BUSY, 1'b1);
      fork
         card_respond(fr, len, dly);
         wait_done();
      join
   endtask

   initial begin
      logic [47:0]  rf;
      logic [119:0] pay, pay_bad;
      logic [31:0]  ocr, a;
      logic [5:0]   ix;
      logic [6:0]   c;
      int           kind, n;

      // reset
      repeat (3) @(negedge CLK);
      chk_reset_state("reset");
      RST = 1'b0;
      repeat (2) @(negedge CLK);

      // CMD0, no response
      run_cmd(6'd0, 32'h0, RESP_NONE, '0, 0, 0);
      check_tx("cmd0", 48'h40_0000_0000_95);
      chk_rng("cmd0_latency", done_cyc - start_cyc - 1, (48 + GC) * 2 * CD - 2, (48 + GC) * 2 * CD + 2);
      chk("cmd0_flags", {TIMEOUT, CRC_ERR, FRAME_ERR}, 3'b000);
      chk("cmd0_resp", RESP, 128'h0);

      // CMD8 with a valid R7 echo
      rf = r1_frame(6'd8, 32'h0000_01AA);
      run_cmd(6'd8, 32'h0000_01AA, RESP_R1, {88'b0, rf}, 48, 5);
      check_tx("cmd8", 48'h48_0000_01AA_87);
      chk("cmd8_resp", RESP, {90'b0, 6'd8, 32'h0000_01AA});
      chk("cmd8_flags", {TIMEOUT, CRC_ERR, FRAME_ERR}, 3'b000);

      // CMD8, card silent
      run_cmd(6'd8, 32'h0000_01AA, RESP_R1, '0, 0, 0);
      chk("to_flag", {TIMEOUT, CRC_ERR, FRAME_ERR}, 3'b100);
      chk("to_rise_count", to_rise - oe_off_rise, TO);
      chk_rng("to_to_done", done_cyc - to_cyc, 2 * CD * GC - 2, 2 * CD * GC);

      // R2, clean then one payload bit flipped
      pay = 120'h23_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      c   = crc7_ref({8'b0, pay}, 120);
      run_cmd(6'd2, 32'h0, RESP_R2, {8'h3F, pay, c, 1'b1}, 136, 3);
      chk("r2_resp", RESP, {8'h00, pay});
      chk("r2_flags", {TIMEOUT, CRC_ERR, FRAME_ERR}, 3'b000);
      pay_bad = pay ^ (120'b1 << $urandom_range(0, 119));
      run_cmd(6'd2, 32'h0, RESP_R2, {8'h3F, pay_bad, c, 1'b1}, 136, 3);
      chk("r2bad_resp", RESP, {8'h00, pay_bad});
      chk("r2bad_flags", {TIMEOUT, CRC_ERR, FRAME_ERR}, 3'b010);

      // R3, bogus CRC field and bad end bit
      ocr = $urandom;
      run_cmd(6'd41, 32'h40FF_8000, RESP_R3, {88'b0, 2'b00, 6'h3F, ocr, 7'h7F, 1'b0}, 48, 2);
      chk("r3_resp", RESP, {90'b0, 6'h3F, ocr});
      chk("r3_flags", {TIMEOUT, CRC_ERR, FRAME_ERR}, 3'b001);

      // randomized R1 exchanges, some with damaged responses
      for (int it = 0; it < 4; it++) begin
         ix   = 6'($urandom_range(0, 63));
         a    = $urandom;
         rf   = r1_frame(6'($urandom_range(0, 63)), $urandom);
         kind = $urandom_range(0, 2);
         if (kind == 1) rf[7:1] = rf[7:1] ^ 7'($urandom_range(1, 127));
         if (kind == 2) begin
            if ($urandom_range(0, 1) == 1) rf[46] = 1'b1;
            else rf[0] = 1'b0;
         end
         run_cmd(ix, a, RESP_R1, {88'b0, rf}, 48, $urandom_range(1, 30));
         check_tx("rnd", cmd_frame(ix, a));
         chk("rnd_resp", RESP, {90'b0, rf[45:8]});
         chk("rnd_flags", {TIMEOUT, CRC_ERR, FRAME_ERR},
             {1'b0, crc7_ref({88'b0, rf[47:8]}, 40) != rf[7:1], rf[46] | ~rf[0]});
      end

      // reset in the middle of SEND
      send_start(6'd17, $urandom, RESP_NONE);
      n = 0;
      while (tx_q.size() < 20 && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("mid_send_reached", tx_q.size(), 20);
      RST = 1'b1;
      @(negedge CLK);
      chk_reset_state("midrst");
      RST = 1'b0;
      @(negedge CLK);

      // CMD55 with a stray START while busy
      send_start(6'd55, 32'h0, RESP_NONE);
      fork
         wait_done();
         begin
            n = 0;
            while (tx_q.size() < 30 && n < 2000) begin
               @(negedge CLK);
               n++;
            end
            CMD_INDEX = 6'd9;
            START     = 1'b1;
            @(negedge CLK);
            START = 1'b0;
         end
      join
      check_tx("cmd55", 48'h77_0000_0000_65);
      chk_rng("cmd55_latency", done_cyc - start_cyc - 1, (48 + GC) * 2 * CD - 2, (48 + GC) * 2 * CD + 2);
      chk("cmd55_flags", {TIMEOUT, CRC_ERR, FRAME_ERR}, 3'b000);
      repeat (10) @(negedge CLK);
      chk("cmd55_idle_after", {BUSY, SD_CLK, CMD_OE}, 3'b000);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
